// File: rtl/fwd_result_pipe.sv
// Forwarding result history: two aged writeback slots feeding operand bypass,
// register-file write from the oldest slot, and load-use stall detection.
module fwd_result_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_wb,
    input  logic        ex_load,
    input  logic [2:0]  ex_dst,
    input  logic [15:0] ex_data,
    input  logic [15:0] mem_rdata,
    input  logic [2:0]  id_src,
    input  logic [2:0]  id_dst,
    input  logic        id_use_src,
    input  logic        id_use_dst,
    input  logic        hold,
    input  logic        flush,
    output logic [2:0]  prev_dst,
    output logic [15:0] prev_data,
    output logic        prev_wb,
    output logic [2:0]  pre_prev_dst,
    output logic [15:0] pre_prev_data,
    output logic        pre_prev_wb,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        load_stall
);

    typedef struct packed {
        logic        valid;
        logic        wb;
        logic        pend;
        logic [2:0]  dst;
        logic [15:0] data;
    } slotP_t;

    typedef struct packed {
        logic        valid;
        logic        wb;
        logic [2:0]  dst;
        logic [15:0] data;
    } slotPP_t;

    slotP_t  slotP;
    slotPP_t slotPP;
    slotP_t  incoming;
    slotPP_t aged;
    logic    srcHit;
    logic    dstHit;
    logic    shiftEn;

    always_comb begin
        srcHit     = id_use_src & (id_src == slotP.dst);
        dstHit     = id_use_dst & (id_dst == slotP.dst);
        load_stall = slotP.valid & slotP.pend & slotP.wb
                   & (srcHit | dstHit) & ~flush;
    end

    always_comb begin
        incoming = '0;
        if (!load_stall) begin
            incoming.valid = ex_valid;
            incoming.wb    = ex_wb;
            incoming.pend  = ex_valid & ex_load;
            incoming.dst   = ex_dst;
            incoming.data  = ex_data;
        end
    end

    // Load data lands in PP on the edge that retires the load out of P.
    always_comb begin
        aged.valid = slotP.valid;
        aged.wb    = slotP.wb;
        aged.dst   = slotP.dst;
        aged.data  = slotP.pend ? mem_rdata : slotP.data;
    end

    assign shiftEn = flush | ~hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotP  <= '0;
            slotPP <= '0;
        end else if (shiftEn) begin
            slotPP <= aged;
            slotP  <= flush ? '0 : incoming;
        end
    end

    assign prev_wb       = slotP.valid & slotP.wb & ~slotP.pend;
    assign prev_dst      = slotP.dst;
    assign prev_data     = slotP.data;
    assign pre_prev_wb   = slotPP.valid & slotPP.wb;
    assign pre_prev_dst  = slotPP.dst;
    assign pre_prev_data = slotPP.data;
    assign rf_we         = pre_prev_wb & ~hold;
    assign rf_waddr      = slotPP.dst;
    assign rf_wdata      = slotPP.data;

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Bench for fwd_result_pipe: directed scenarios with literal expectations,
// then random traffic against an instruction-history reference model.
module tb_fwd_result_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_wb, ex_load;
    logic [2:0]  ex_dst;
    logic [15:0] ex_data, mem_rdata;
    logic [2:0]  id_src, id_dst;
    logic        id_use_src, id_use_dst, hold, flush;
    logic [2:0]  prev_dst, pre_prev_dst, rf_waddr;
    logic [15:0] prev_data, pre_prev_data, rf_wdata;
    logic        prev_wb, pre_prev_wb, rf_we, load_stall;

    int nChecks = 0;
    int nFails  = 0;

    fwd_result_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_wb(ex_wb), .ex_load(ex_load),
        .ex_dst(ex_dst), .ex_data(ex_data), .mem_rdata(mem_rdata),
        .id_src(id_src), .id_dst(id_dst),
        .id_use_src(id_use_src), .id_use_dst(id_use_dst),
        .hold(hold), .flush(flush),
        .prev_dst(prev_dst), .prev_data(prev_data), .prev_wb(prev_wb),
        .pre_prev_dst(pre_prev_dst), .pre_prev_data(pre_prev_data),
        .pre_prev_wb(pre_prev_wb),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .load_stall(load_stall)
    );

    always #5 clk = ~clk;

    // Reference: the newest instruction (N) and the one before it (O).
    // A load in N has no data yet; it gets mem_rdata when it becomes O.
    typedef struct {
        bit       valid;
        bit       wb;
        bit       isLoad;
        bit [2:0] dst;
        bit [15:0] data;
    } instr_t;

    instr_t mN, mO;

    function automatic instr_t emptyInstr();
        instr_t e;
        e.valid = 0; e.wb = 0; e.isLoad = 0; e.dst = 0; e.data = 0;
        return e;
    endfunction

    function automatic bit expStall();
        bit dep;
        dep = (id_use_src && id_src == mN.dst) || (id_use_dst && id_dst == mN.dst);
        return mN.valid && mN.isLoad && mN.wb && dep && !flush;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        bit eStall;
        eStall = expStall();
        chk("load_stall", 16'(load_stall), 16'(eStall));
        chk("prev_wb", 16'(prev_wb), 16'(mN.valid && mN.wb && !mN.isLoad));
        chk("pre_prev_wb", 16'(pre_prev_wb), 16'(mO.valid && mO.wb));
        chk("rf_we", 16'(rf_we), 16'(mO.valid && mO.wb && !hold));
        if (mN.valid) begin
            chk("prev_dst", 16'(prev_dst), 16'(mN.dst));
            chk("prev_data", prev_data, mN.data);
        end
        if (mO.valid) begin
            chk("pre_prev_dst", 16'(pre_prev_dst), 16'(mO.dst));
            chk("pre_prev_data", pre_prev_data, mO.data);
            chk("rf_waddr", 16'(rf_waddr), 16'(mO.dst));
            chk("rf_wdata", rf_wdata, mO.data);
        end
    endtask

    task automatic updateModel();
        instr_t nxt;
        bit stall;
        if (!rst_n) begin
            mN = emptyInstr();
            mO = emptyInstr();
            return;
        end
        stall = expStall();
        if (flush || !hold) begin
            mO = mN;
            if (mN.isLoad) mO.data = mem_rdata;
            mO.isLoad = 0;
            nxt = emptyInstr();
            if (!flush && !stall) begin
                nxt.valid  = ex_valid;
                nxt.wb     = ex_wb;
                nxt.isLoad = ex_valid && ex_load;
                nxt.dst    = ex_dst;
                nxt.data   = ex_data;
            end
            mN = nxt;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compareModel();
    endtask

    task automatic tick();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_wb = 0; ex_load = 0; ex_dst = 0; ex_data = 0;
        id_use_src = 0; id_use_dst = 0; id_src = 0; id_dst = 0;
        hold = 0; flush = 0;
    endtask

    task automatic alu(bit [2:0] d, bit [15:0] v);
        ex_valid = 1; ex_wb = 1; ex_load = 0; ex_dst = d; ex_data = v;
    endtask

    task automatic drain();
        idle();
        repeat (3) begin sample(); tick(); end
    endtask

    initial begin
        mN = emptyInstr();
        mO = emptyInstr();
        idle();
        mem_rdata = 0;
        rst_n = 0;
        #2;
        chk("reset prev_wb", 16'(prev_wb), 16'h0);
        chk("reset rf_we", 16'(rf_we), 16'h0);
        chk("reset pre_prev_data", pre_prev_data, 16'h0);
        repeat (2) tick();
        rst_n = 1;

        // Two ALU writes back to back
        alu(3, 16'h1234); sample(); tick();
        alu(5, 16'hBEEF); sample(); tick();
        idle(); sample();
        chk("t1 prev_dst", 16'(prev_dst), 16'h5);
        chk("t1 prev_data", prev_data, 16'hBEEF);
        chk("t1 pre_prev_dst", 16'(pre_prev_dst), 16'h3);
        chk("t1 pre_prev_data", pre_prev_data, 16'h1234);
        chk("t1 rf_we", 16'(rf_we), 16'h1);
        chk("t1 rf_waddr", 16'(rf_waddr), 16'h3);
        chk("t1 rf_wdata", rf_wdata, 16'h1234);
        tick();
        drain();

        // Dependent load: one stall cycle, decode instruction bubbled
        alu(2, 16'h0BAD); ex_load = 1; sample(); tick();
        alu(7, 16'h7070); mem_rdata = 16'hA5A5;
        id_src = 2; id_use_src = 1; sample();
        chk("t2 load_stall", 16'(load_stall), 16'h1);
        chk("t2 prev_wb", 16'(prev_wb), 16'h0);
        tick();
        idle(); mem_rdata = 16'h0; sample();
        chk("t2 load_stall after", 16'(load_stall), 16'h0);
        chk("t2 pre_prev_data", pre_prev_data, 16'hA5A5);
        chk("t2 rf_wdata", rf_wdata, 16'hA5A5);
        chk("t2 rf_we", 16'(rf_we), 16'h1);
        chk("t2 bubble prev_wb", 16'(prev_wb), 16'h0);
        tick();
        drain();

        // Independent load: no stall, no bubble
        alu(2, 16'h0); ex_load = 1; sample(); tick();
        alu(4, 16'h4444); mem_rdata = 16'h5A5A;
        id_src = 4; id_use_src = 1; sample();
        chk("t3 load_stall", 16'(load_stall), 16'h0);
        tick();
        idle(); sample();
        chk("t3 prev_wb", 16'(prev_wb), 16'h1);
        chk("t3 prev_dst", 16'(prev_dst), 16'h4);
        chk("t3 pre_prev_data", pre_prev_data, 16'h5A5A);
        tick();
        drain();

        // Hold freezes both slots and suppresses the write
        alu(6, 16'h0006); sample(); tick();
        alu(1, 16'h0001); sample(); tick();
        idle(); hold = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t4 hold prev_data", prev_data, 16'h0001);
            chk("t4 hold pre_prev_dst", 16'(pre_prev_dst), 16'h6);
            chk("t4 hold rf_we", 16'(rf_we), 16'h0);
            tick();
        end
        hold = 0; sample();
        chk("t4 release rf_we", 16'(rf_we), 16'h1);
        chk("t4 release waddr", 16'(rf_waddr), 16'h6);
        tick(); sample();
        chk("t4 next waddr", 16'(rf_waddr), 16'h1);
        tick();
        drain();

        // Flush squashes execute, older instruction still retires
        alu(1, 16'h0011); sample(); tick();
        alu(7, 16'h7777); flush = 1; sample(); tick();
        idle(); sample();
        chk("t5 prev_wb", 16'(prev_wb), 16'h0);
        chk("t5 rf_we", 16'(rf_we), 16'h1);
        chk("t5 rf_waddr", 16'(rf_waddr), 16'h1);
        tick(); sample();
        chk("t5 r7 absent", 16'(pre_prev_wb), 16'h0);
        tick();
        drain();

        // Reset while load pending
        alu(3, 16'h0); ex_load = 1; sample(); tick();
        idle(); mem_rdata = 16'hDEAD;
        #2 rst_n = 0;
        #1;
        chk("t6 prev_wb", 16'(prev_wb), 16'h0);
        chk("t6 prev_dst", 16'(prev_dst), 16'h0);
        chk("t6 pre_prev_wb", 16'(pre_prev_wb), 16'h0);
        chk("t6 rf_wdata", rf_wdata, 16'h0);
        chk("t6 load_stall", 16'(load_stall), 16'h0);
        tick();
        rst_n = 1;
        sample(); tick();
        sample();
        chk("t6 no stale write", 16'(rf_we), 16'h0);
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_wb      = ($urandom_range(0, 4) != 0);
            ex_load    = ($urandom_range(0, 2) == 0);
            ex_dst     = 3'($urandom_range(0, 7));
            ex_data    = 16'($urandom);
            mem_rdata  = 16'($urandom);
            id_src     = 3'($urandom_range(0, 7));
            id_dst     = 3'($urandom_range(0, 7));
            id_use_src = ($urandom_range(0, 1) == 1);
            id_use_dst = ($urandom_range(0, 1) == 1);
            hold       = ($urandom_range(0, 5) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            sample();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fwd_result_pipe.md
# fwd_result_pipe

Producer side of the operand-forwarding path. Captures each executed instruction's writeback result, ages it through two history slots (prev, pre-prev) and presents them as forwarding sources to the operand-bypass logic. It also drives the register-file write port from the oldest slot and raises a load-use stall while a load's data is still outstanding. Sits between the execute stage and the register file, alongside the forwarding unit.

## Interface
- No parameters; data width 16, register index width 3 are fixed.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  an instruction leaves execute this cycle
- ex_wb  in  1  that instruction writes a register
- ex_load  in  1  that instruction is a load (data arrives one cycle later)
- ex_dst  in  3  destination register index
- ex_data  in  16  ALU result (ignored when ex_load=1)
- mem_rdata  in  16  load data, valid the cycle after the load is captured
- id_src, id_dst  in  3 each  operand indices of the instruction in decode
- id_use_src, id_use_dst  in  1 each  that operand is actually read
- hold  in  1  global pipeline freeze
- flush  in  1  squash wrong-path instruction
- prev_dst / prev_data / prev_wb  out  3/16/1  newest forwarding source
- pre_prev_dst / pre_prev_data / pre_prev_wb  out  3/16/1  older forwarding source
- rf_we / rf_waddr / rf_wdata  out  1/3/16  register-file write port
- load_stall  out  1  decode must hold; bubble inserted

## Operation
- Slot P fields: valid, wb, pend, dst, data. Slot PP fields: valid, wb, dst, data.
- Normal edge (no hold, no flush): PP <= P, with PP.data <= mem_rdata if P.pend else P.data; P <= incoming.
- Incoming to P: if load_stall then bubble (valid=0); else valid=ex_valid, wb=ex_wb, pend=ex_valid&ex_load, dst=ex_dst, data=ex_data.
- hold=1: P and PP keep all fields; load_stall still evaluated combinationally.
- flush=1: P <= bubble; PP <= P as in normal edge (the older instruction already committed). flush overrides hold.
- prev_wb = P.valid & P.wb & ~P.pend (pending load data is never forwarded). prev_dst=P.dst, prev_data=P.data.
- pre_prev_wb = PP.valid & PP.wb; pre_prev_dst=PP.dst; pre_prev_data=PP.data.
- rf_we = pre_prev_wb; rf_waddr = PP.dst; rf_wdata = PP.data. rf_we forced 0 while hold=1 (no duplicate writes).
- load_stall = P.valid & P.pend & P.wb & ((id_use_src & id_src==P.dst) | (id_use_dst & id_dst==P.dst)) & ~flush.
- Register 0 has no special treatment; index compares are plain 3-bit equality.

## Timing
- Reset (async, rst_n=0): P and PP valid/wb/pend=0, dst=0, data=0; so all outputs 0, load_stall=0. Release takes effect at next edge; reset mid-load discards pending data.
- Latency: ex result visible on prev_* one cycle after capture, on pre_prev_* two cycles, written to RF in the cycle it sits in PP.
- Load: captured in P at edge t (prev_wb=0), mem_rdata sampled at edge t+1 into PP, forwarded via pre_prev_* and written during cycle t+1..t+2.
- load_stall lasts exactly one cycle per dependent load unless hold=1, in which case it persists until hold drops.
- Simultaneous hold and load data: with hold=1, P.pend stays 1; mem_rdata must be held stable by memory until the shift edge.
- Back-to-back writes to the same register: both slots may match; priority to P is the consumer's job.

## Test plan
- ALU writes r3=0x1234 then r5=0xBEEF on consecutive cycles -> next cycle prev_dst=5/0xBEEF, pre_prev_dst=3/0x1234, rf_we=1 waddr=3 wdata=0x1234.
- Load r2, mem_rdata=0xA5A5 next cycle, decode reads r2 as src -> load_stall=1 one cycle, prev_wb=0; following cycle pre_prev_data=0xA5A5, rf_wdata=0xA5A5, P is bubble.
- Load r2, decode reads r4 only -> load_stall=0, no bubble.
- hold=1 for 3 cycles with P=r1/0x0001, PP=r6/0x0006 -> outputs unchanged, rf_we=0 throughout; rf_we=1 for r6 exactly once after release.
- flush with r7=0x7777 in execute and r1 in P -> r7 never appears on prev_*; r1 advances to PP and is written.
- rst_n low while load pending -> all outputs 0 immediately; after release no write of stale load data.
